// File: rtl/wb_ram_ctrl.sv
// Wishbone classic (B4) slave with an integrated byte-enabled RAM.
// It decodes an address window, has a configurable registered read latency, and aborts a read when cyc drops.
module wb_ram_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE         = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o
);

  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned BYTE_BITS = $clog2(NB);
  localparam int unsigned DEPTH     = SIZE / NB;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SIZE_W    = 32'(SIZE);
  localparam logic [1:0]  LAT_M1    = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   ram_q [DEPTH];

  logic [31:0]             off;
  logic                    in_range;
  logic [AW-1:0]           word_idx;
  logic                    ram_we;
  logic                    rd_load;

  // The offset wraps for addresses below BASE_ADDR, so a single compare covers both edges of the window.
  assign off      = wb_adr_i - BASE_ADDR;
  assign in_range = off < SIZE_W;
  assign word_idx = off[BYTE_BITS +: AW];

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_d      = rd_q;
    ram_we    = 1'b0;
    rd_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d = RESP;
          err_d   = !in_range;
          rd_d    = 1'b0;
          if (in_range && wb_we_i) begin
            ram_we = 1'b1;
          end else if (in_range) begin
            rd_load = 1'b1;
            rd_d    = 1'b1;
            cnt_d   = LAT_M1;
            if (LAT_M1 != 2'd0) state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          rd_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_data_d = rd_load ? ram_q[word_idx] : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the RAM array has no reset. Its contents survive rstn_i, and it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wb_sel_i[b]) ram_q[word_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
  end

  assign wb_ack_o = (state_q == RESP) && !err_q;
  assign wb_err_o = (state_q == RESP) && err_q;
  assign wb_dat_o = ((state_q == RESP) && rd_q) ? rd_data_q : '0;

endmodule
